spi_reg_cmd_ctrl: RTL

- Command/sequencing controller that sits on the i_Clk side of the SPI slave byte interface.
- Consumes received bytes (RX DV/byte) and decodes a command byte, then runs auto-incrementing register writes or reads on a simple local register bus.
- Feeds the slave's TX byte register so that read data is shifted out on MISO in the byte frame following each request.
- Synchronises chip-select itself so it can frame transactions and abort them.

---
 rtl/spi_ctrl_pkg.sv | 18 +
 rtl/spi_cs_sync.sv | 37 +++
 rtl/spi_reg_cmd_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI register command controller.
// Holds the FSM state encoding, the command byte layout and the default TX bytes.
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR_DATA,
        RD_REQ,
        RD_WAIT,
        RD_DATA
    } state_e;

    localparam int         CMD_RW_BIT      = 7;
    localparam logic [7:0] DEF_STATUS_BYTE = 8'hA5;
    localparam logic [7:0] DEF_ERR_BYTE    = 8'hEE;

endpackage

// File: rtl/spi_cs_sync.sv
// Three-flop chip-select synchroniser producing one-cycle start (falling) and end (rising) pulses.
// Edges are only reported once CS has been seen high after reset, so a CS held low through reset is ignored.
module spi_cs_sync (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_CS_n,
    output logic o_CS_Start,
    output logic o_CS_End
);

    logic [2:0] sync_q, sync_d;
    logic [1:0] fill_q, fill_d;
    logic       armed_q, armed_d;

    always_comb begin
        sync_d  = {sync_q[1:0], i_CS_n};
        fill_d  = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
        // Arm only after the chain holds real samples and those samples show CS high.
        armed_d = armed_q | ((fill_q == 2'd3) & sync_q[2] & sync_q[1]);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_q  <= 3'b111;
            fill_q  <= 2'd0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            fill_q  <= fill_d;
            armed_q <= armed_d;
        end
    end

    assign o_CS_Start = armed_q &  sync_q[2] & ~sync_q[1];
    assign o_CS_End   = armed_q & ~sync_q[2] &  sync_q[1];

endmodule

// File: rtl/spi_reg_cmd_ctrl.sv
// Decodes SPI command bytes and runs auto-incrementing register writes/reads,
// feeding the SPI slave TX register with status, read data or an error byte.
module spi_reg_cmd_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int         ADDR_W      = 7,
    parameter logic [7:0] STATUS_BYTE = DEF_STATUS_BYTE,
    parameter logic [7:0] ERR_BYTE    = DEF_ERR_BYTE,
    parameter int         RD_TIMEOUT  = 16
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic              i_SPI_CS_n,
    input  logic              i_RX_DV,
    input  logic [7:0]        i_RX_Byte,
    output logic              o_TX_DV,
    output logic [7:0]        o_TX_Byte,
    output logic [ADDR_W-1:0] o_Reg_Addr,
    output logic              o_Reg_WR,
    output logic [7:0]        o_Reg_WData,
    output logic              o_Reg_RD,
    input  logic              i_Reg_RD_DV,
    input  logic [7:0]        i_Reg_RData,
    output logic              o_Busy,
    output logic              o_Err_Timeout,
    input  logic              i_Clear_Err
);

    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

    logic              cs_start, cs_end;
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tx_dv_q, tx_dv_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              wr_q, wr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              rx_unused;

    // Command bits between the address field and the rw bit carry no meaning.
    assign rx_unused = ^i_RX_Byte;

    spi_cs_sync u_cs_sync (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .i_CS_n     (i_SPI_CS_n),
        .o_CS_Start (cs_start),
        .o_CS_End   (cs_end)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        wr_d      = 1'b0;
        wdata_d   = wdata_q;
        err_d     = i_Clear_Err ? 1'b0 : err_q;

        // Post-increment after the write strobe has been presented with the current address.
        if (wr_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (cs_start) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = STATUS_BYTE;
                    state_d   = CMD;
                end
            end
            CMD: begin
                if (cs_end) begin
                    state_d = IDLE;
                end else if (i_RX_DV) begin
                    addr_d = i_RX_Byte[ADDR_W-1:0];
                    if (i_RX_Byte[CMD_RW_BIT]) begin
                        state_d = RD_REQ;
                    end else begin
                        tx_dv_d   = 1'b1;
                        tx_byte_d = 8'h00;
                        state_d   = WR_DATA;
                    end
                end
            end
            WR_DATA: begin
                // A data byte landing with CS end is still committed.
                if (i_RX_DV) begin
                    wr_d    = 1'b1;
                    wdata_d = i_RX_Byte;
                end
                if (cs_end) begin
                    state_d = IDLE;
                end
            end
            RD_REQ: begin
                cnt_d   = '0;
                state_d = cs_end ? IDLE : RD_WAIT;
            end
            RD_WAIT: begin
                if (cs_end) begin
                    state_d = IDLE;
                end else if (i_Reg_RD_DV) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = i_Reg_RData;
                    addr_d    = addr_q + ADDR_W'(1);
                    state_d   = RD_DATA;
                end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = ERR_BYTE;
                    err_d     = 1'b1;
                    addr_d    = addr_q + ADDR_W'(1);
                    state_d   = RD_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_DATA: begin
                if (cs_end) begin
                    state_d = IDLE;
                end else if (i_RX_DV) begin
                    state_d = RD_REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
            wr_q      <= 1'b0;
            wdata_q   <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
        end
    end

    assign o_TX_DV       = tx_dv_q;
    assign o_TX_Byte     = tx_byte_q;
    assign o_Reg_Addr    = addr_q;
    assign o_Reg_WR      = wr_q;
    assign o_Reg_WData   = wdata_q;
    assign o_Reg_RD      = (state_q == RD_REQ);
    assign o_Busy        = (state_q != IDLE);
    assign o_Err_Timeout = err_q;

endmodule
